// File: rtl/vco_adc_pkg.sv
// Shared definitions for the VCO-ADC sample controller: state encoding and
// default widths used by the top level and the popcount sub-module.
package vco_adc_pkg;

  localparam int PHASE_WIDTH_DEF  = 11;
  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int WIN_WIDTH_DEF    = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/phase_popcount.sv
// Counts the transition flags asserted in one phase-readout word.
module phase_popcount
  import vco_adc_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int POP_WIDTH   = $clog2(PHASE_WIDTH + 1)
) (
  input  logic [PHASE_WIDTH-1:0] i_phase,
  output logic [POP_WIDTH-1:0]   o_count
);

  logic [POP_WIDTH-1:0] w_count;

  // Ripple sum of the individual flag bits.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < PHASE_WIDTH; i++) begin
      w_count = w_count + POP_WIDTH'(i_phase[i]);
    end
  end

  assign o_count = w_count;

endmodule

// File: rtl/vco_adc_sample_ctrl.sv
// Windowed decimator for a VCO-based ADC: sums transition counts over an
// N-cycle window, saturating, and hands each window sum to a consumer
// through a valid/ready register with a sticky overrun flag.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | converter disabled; accumulator/counter held at zero
//   ST_ACCUM | accumulating popcount(phase_i) every edge, windows back to back
module vco_adc_sample_ctrl
  import vco_adc_pkg::*;
#(
  parameter int PHASE_WIDTH  = PHASE_WIDTH_DEF,
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int WIN_WIDTH    = WIN_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [WIN_WIDTH-1:0]    win_len_i,
  input  logic [PHASE_WIDTH-1:0]  phase_i,
  output logic [SAMPLE_WIDTH-1:0] sample_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    overrun_o,
  input  logic                    clr_overrun_i,
  output logic                    busy_o
);

  localparam int POP_WIDTH = $clog2(PHASE_WIDTH + 1);
  localparam int SUM_WIDTH = SAMPLE_WIDTH + 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_busy;
  logic [WIN_WIDTH-1:0]    r_win_len;
  logic [WIN_WIDTH-1:0]    r_cnt;
  logic [SAMPLE_WIDTH-1:0] r_acc;
  logic [SAMPLE_WIDTH-1:0] r_sample;
  logic                    r_valid;
  logic                    r_overrun;
  logic [POP_WIDTH-1:0]    w_pop;
  logic [SUM_WIDTH-1:0]    w_sum;
  logic [SAMPLE_WIDTH-1:0] w_acc_sat;
  logic                    w_accum_en;
  logic                    w_win_end;
  logic                    w_load_win;
  logic                    w_xfer;
  logic                    w_drop;

  phase_popcount #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .POP_WIDTH   (POP_WIDTH)
  ) u_popcount (
    .i_phase (phase_i),
    .o_count (w_pop)
  );

  // The extra sum bit is the carry out; any carry pins the result at full scale.
  assign w_sum     = {1'b0, r_acc} + SUM_WIDTH'(w_pop);
  assign w_acc_sat = w_sum[SAMPLE_WIDTH] ? '1 : w_sum[SAMPLE_WIDTH-1:0];

  // An ACCUM edge with enable low is the exit edge: it neither accumulates
  // nor closes a window.
  assign w_accum_en = (r_state == ST_ACCUM) && enable_i;
  assign w_win_end  = w_accum_en && (r_cnt == r_win_len);
  assign w_load_win = ((r_state == ST_IDLE) && enable_i) || w_win_end;
  assign w_xfer     = w_win_end && (!r_valid || ready_i);
  assign w_drop     = w_win_end && r_valid && !ready_i;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and busy indication.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE:  if (enable_i) w_state_nxt = ST_ACCUM;
      ST_ACCUM: begin
        w_busy = 1'b1;
        if (!enable_i) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Window length capture, accumulator and cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_len <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_load_win) r_win_len <= win_len_i;
      if (w_accum_en && !w_win_end) begin
        r_acc <= w_acc_sat;
        r_cnt <= r_cnt + WIN_WIDTH'(1);
      end else begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end

  // Output sample register, valid/ready handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_sample <= w_acc_sat;
        r_valid  <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid  <= 1'b0;
      end
      if (w_drop)             r_overrun <= 1'b1;
      else if (clr_overrun_i) r_overrun <= 1'b0;
    end
  end

  assign sample_o  = r_sample;
  assign valid_o   = r_valid;
  assign overrun_o = r_overrun;
  assign busy_o    = w_busy;

endmodule

// File: tb/tb_vco_adc_sample_ctrl.sv
// Directed bench for vco_adc_sample_ctrl: a cycle table for streaming,
// back-pressure and overrun, then hand sequences for enable drop, reset with a
// pending sample, single-cycle windows and saturation on an 8-bit instance.
module tb_vco_adc_sample_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [7:0]  win_len_i;
  logic [10:0] phase_i;
  logic        ready_i;
  logic        clr_overrun_i;

  logic [15:0] sample_o;
  logic        valid_o, overrun_o, busy_o;
  logic [7:0]  sample8_o;
  logic        valid8_o, overrun8_o, busy8_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vco_adc_sample_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .win_len_i     (win_len_i),
    .phase_i       (phase_i),
    .sample_o      (sample_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .overrun_o     (overrun_o),
    .clr_overrun_i (clr_overrun_i),
    .busy_o        (busy_o)
  );

  vco_adc_sample_ctrl #(.SAMPLE_WIDTH(8)) dut8 (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .win_len_i     (win_len_i),
    .phase_i       (phase_i),
    .sample_o      (sample8_o),
    .valid_o       (valid8_o),
    .ready_i       (ready_i),
    .overrun_o     (overrun8_o),
    .clr_overrun_i (clr_overrun_i),
    .busy_o        (busy8_o)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [7:0]  win;
    logic [10:0] phase;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [15:0] es;
    logic        eo;
    logic        eb;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic e, logic [7:0] w, logic [10:0] p,
                              logic rd, logic c, logic ev, logic [15:0] es,
                              logic eo, logic eb);
    vec_t v;
    v.rst_n = r; v.en = e; v.win = w; v.phase = p; v.rdy = rd; v.clr = c;
    v.ev = ev; v.es = es; v.eo = eo; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [15:0] es,
                         input logic eo, input logic eb);
    chk({tag, " valid"},   {31'd0, valid_o},   {31'd0, ev});
    chk({tag, " sample"},  {16'd0, sample_o},  {16'd0, es});
    chk({tag, " overrun"}, {31'd0, overrun_o}, {31'd0, eo});
    chk({tag, " busy"},    {31'd0, busy_o},    {31'd0, eb});
  endtask

  initial begin
    rst_n = 1'b0; enable_i = 1'b0; win_len_i = '0; phase_i = '0;
    ready_i = 1'b0; clr_overrun_i = 1'b0;

    // rst en win phase rdy clr | valid sample overrun busy
    vt.push_back(mk(0, 0, 0, 11'h000, 0, 0, 0,  0, 0, 0));
    vt.push_back(mk(1, 1, 3, 11'h7FF, 1, 0, 0,  0, 0, 1));
    vt.push_back(mk(1, 1, 3, 11'h7FF, 1, 0, 0,  0, 0, 1));
    vt.push_back(mk(1, 1, 3, 11'h7FF, 1, 0, 0,  0, 0, 1));
    vt.push_back(mk(1, 1, 3, 11'h7FF, 1, 0, 0,  0, 0, 1));
    vt.push_back(mk(1, 1, 3, 11'h7FF, 1, 0, 1, 44, 0, 1));
    vt.push_back(mk(1, 1, 3, 11'h7FF, 1, 0, 0, 44, 0, 1));
    vt.push_back(mk(1, 1, 3, 11'h7FF, 1, 0, 0, 44, 0, 1));
    vt.push_back(mk(1, 1, 3, 11'h7FF, 1, 0, 0, 44, 0, 1));
    vt.push_back(mk(1, 1, 3, 11'h7FF, 1, 0, 1, 44, 0, 1));
    vt.push_back(mk(1, 0, 3, 11'h7FF, 1, 0, 0, 44, 0, 0));
    vt.push_back(mk(1, 1, 1, 11'h003, 0, 0, 0, 44, 0, 1));
    vt.push_back(mk(1, 1, 1, 11'h003, 0, 0, 0, 44, 0, 1));
    vt.push_back(mk(1, 1, 1, 11'h003, 0, 0, 1,  4, 0, 1));
    vt.push_back(mk(1, 1, 1, 11'h003, 0, 0, 1,  4, 0, 1));
    vt.push_back(mk(1, 1, 1, 11'h003, 0, 0, 1,  4, 1, 1));
    vt.push_back(mk(1, 1, 1, 11'h003, 0, 0, 1,  4, 1, 1));
    vt.push_back(mk(1, 1, 1, 11'h003, 0, 1, 1,  4, 1, 1));
    vt.push_back(mk(1, 1, 1, 11'h003, 0, 1, 1,  4, 0, 1));
    vt.push_back(mk(1, 1, 1, 11'h001, 1, 0, 1,  3, 0, 1));
    vt.push_back(mk(1, 0, 1, 11'h001, 1, 0, 0,  3, 0, 0));

    #1;
    foreach (vt[i]) begin
      rst_n = vt[i].rst_n; enable_i = vt[i].en; win_len_i = vt[i].win;
      phase_i = vt[i].phase; ready_i = vt[i].rdy; clr_overrun_i = vt[i].clr;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].es, vt[i].eo, vt[i].eb);
    end

    // Enable dropped after 2 of 8 cycles: partial window is lost.
    enable_i = 1'b1; win_len_i = 8'd7; phase_i = 11'h7FF; ready_i = 1'b1; clr_overrun_i = 1'b0;
    step();
    step();
    step();
    enable_i = 1'b0;
    step();
    chk("drop busy", {31'd0, busy_o}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("drop idle%0d valid", k), {31'd0, valid_o}, 32'd0);
    end
    enable_i = 1'b1; phase_i = 11'h001;
    step();
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("rewin%0d valid", k), {31'd0, valid_o}, 32'd0);
    end
    step();
    chk("rewin end valid", {31'd0, valid_o}, 32'd1);
    chk("rewin end sample", {16'd0, sample_o}, 32'd8);

    // Build a pending sample plus overrun, then reset mid-window.
    ready_i = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("pre-rst overrun", {31'd0, overrun_o}, 32'd1);
    chk("pre-rst sample", {16'd0, sample_o}, 32'd8);
    step();
    step();
    chk("pre-rst valid", {31'd0, valid_o}, 32'd1);
    rst_n = 1'b0;
    step();
    chk_all("rst", 1'b0, 16'd0, 1'b0, 1'b0);

    // Single-cycle windows after reset: each sample is the previous cycle's popcount.
    rst_n = 1'b1; enable_i = 1'b1; win_len_i = 8'd0; ready_i = 1'b1; phase_i = 11'h7FF;
    step();
    chk("n1 entry busy", {31'd0, busy_o}, 32'd1);
    chk("n1 entry valid", {31'd0, valid_o}, 32'd0);
    begin
      logic [10:0] ph [4];
      int          pc [4];
      ph[0] = 11'h7FF; pc[0] = 11;
      ph[1] = 11'h001; pc[1] = 1;
      ph[2] = 11'h000; pc[2] = 0;
      ph[3] = 11'h555; pc[3] = 6;
      for (int k = 0; k < 4; k++) begin
        phase_i = ph[k];
        step();
        chk($sformatf("n1 %0d valid", k), {31'd0, valid_o}, 32'd1);
        chk($sformatf("n1 %0d sample", k), {16'd0, sample_o}, pc[k]);
      end
    end

    // Saturation on the 8-bit instance over a 256-cycle window.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; enable_i = 1'b1; win_len_i = 8'd255; phase_i = 11'h7FF; ready_i = 1'b1;
    step();
    begin
      int  n    = 0;
      bit  seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
        step();
        n++;
        if (valid8_o) seen = 1'b1;
      end
      chk("sat window cycles", n, 32'd256);
      chk("sat sample8", {24'd0, sample8_o}, 32'd255);
      chk("sat sample16", {16'd0, sample_o}, 32'd2816);
      chk("sat overrun8", {31'd0, overrun8_o}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vco_adc_sample_ctrl.md
VCO_ADC_SAMPLE_CTRL -- requirements
Module: vco_adc_sample_ctrl

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 11, width of the phase-difference vector from the phase readout.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16, width of the output sample.
REQ-003 SHALL have parameter WIN_WIDTH, default 8, width of the window-length control.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port enable_i  input  1  conversion enable.
REQ-007 SHALL have port win_len_i  input  WIN_WIDTH  window length minus one; window length N = win_len_i+1 cycles.
REQ-008 SHALL have port phase_i  input  PHASE_WIDTH  per-phase transition flags from the phase readout.
REQ-009 SHALL have port sample_o  output  SAMPLE_WIDTH  decimated sample.
REQ-010 SHALL have port valid_o  output  1  sample_o holds an unconsumed sample.
REQ-011 SHALL have port ready_i  input  1  consumer accepts sample_o.
REQ-012 SHALL have port overrun_o  output  1  sticky flag: a completed sample was dropped.
REQ-013 SHALL have port clr_overrun_i  input  1  clears overrun_o.
REQ-014 SHALL have port busy_o  output  1  high while state is ACCUM.

Function
REQ-015 SHALL implement FSM states IDLE and ACCUM; IDLE->ACCUM when enable_i=1; ACCUM->IDLE when enable_i=0.
REQ-016 SHALL latch win_len_i into a window register on every IDLE->ACCUM transition and at every window end; mid-window changes to win_len_i have no effect on the current window.
REQ-017 SHALL, on each edge in ACCUM, add popcount(phase_i) (0..PHASE_WIDTH) to the accumulator and increment the cycle counter.
REQ-018 SHALL saturate the accumulator at 2^SAMPLE_WIDTH-1; no wrap-around.
REQ-019 SHALL end a window on the edge accumulating the Nth cycle: sum including that cycle is offered for transfer, accumulator and counter restart at zero, next window accumulates from the following edge with no gap cycles.
REQ-020 SHALL transfer the window sum into sample_o and set valid_o on the window-end edge if valid_o=0, or if valid_o=1 and ready_i=1 on that edge; latency one edge from last accumulated cycle to valid_o=1.
REQ-021 SHALL, at window end with valid_o=1 and ready_i=0, discard the new sum, keep sample_o unchanged and set overrun_o.
REQ-022 SHALL clear valid_o on an edge with valid_o=1 and ready_i=1 unless a transfer per REQ-020 occurs on that same edge.
REQ-023 SHALL hold sample_o stable while valid_o=1 and ready_i=0.
REQ-024 SHALL, on ACCUM->IDLE, discard the partial window (accumulator and counter to zero); a pending sample_o/valid_o is retained and the handshake still completes in IDLE.
REQ-025 SHALL clear overrun_o when clr_overrun_i=1; if a drop and clr_overrun_i coincide, overrun_o is set (set wins).
REQ-026 SHALL support win_len_i=0 (N=1): a window ends on every ACCUM edge.

Reset
REQ-027 SHALL, on an edge with rst_n=0, force state IDLE, accumulator 0, counter 0, window register 0, sample_o=0, valid_o=0, overrun_o=0, busy_o=0, regardless of current state or pending handshake.
REQ-028 SHALL resume per REQ-015 on the first edge with rst_n=1.

Structure
REQ-029 SHALL place the state encoding and default parameter values in the shared package vco_adc_pkg.
REQ-030 SHALL implement popcount as combinational sub-module phase_popcount, parameterised by PHASE_WIDTH.

Verification
REQ-031 SHALL cover: win_len_i=3, phase_i=11'h7FF constant, ready_i=1 -> sample_o=44 every 4 cycles, valid_o one cycle each, overrun_o=0.
REQ-032 SHALL cover: win_len_i=1, phase_i=11'h003, ready_i=0 for 6 cycles -> first sample 4 held, overrun_o=1 after second window end; clr_overrun_i pulse -> overrun_o=0.
REQ-033 SHALL cover: enable_i dropped after 2 of 8 window cycles -> no new valid_o; re-enable gives full 8-cycle window from zero.
REQ-034 SHALL cover: SAMPLE_WIDTH=8, win_len_i=255, phase_i=11'h7FF -> sample_o=255 (saturated), not 2816 mod 256.
REQ-035 SHALL cover: rst_n=0 asserted mid-window with valid_o=1 -> next cycle all outputs 0, state IDLE; win_len_i=0 after reset -> valid sample each cycle equal to popcount(phase_i) of previous cycle.
